uart_control_receiver: RTL and testbench
========================================

# uart_control_receiver

- Receive-side controller of the UART.
- Recovers 8N1-style frames from the serial line using a 16x oversampling baud tick and assembles the data bits into a byte.
- Pushes each good byte into the RX FIFO.
- Gates host reads of that FIFO and flags framing, overrun and read-underflow errors.
- Sits between the pad-side serial input, the shared baud generator and the RX FIFO, mirroring the transmit-side controller.

## Interface
Parameters:
- DATA_BITS, 8, data bits per frame (5..8).
- OVERSAMPLE, 16, baud_tick pulses per bit period (even, >=8).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset, synchronous, active-low.
- baud_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate.
- rx_serial  input  1  asynchronous serial line; idle high.
- full  input  1  RX FIFO full.
- empty  input  1  RX FIFO empty.
- read_data  input  1  host request to pop RX FIFO.
- rx_data  output  DATA_BITS  received byte, valid while write=1.
- write  output  1  RX FIFO push strobe, one clk.
- read  output  1  RX FIFO pop strobe.
- busy  output  1  frame reception in progress.
- error_framing  output  1  one-clk pulse: stop bit sampled low.
- error_overrun  output  1  one-clk pulse: good frame dropped because FIFO full.
- error_read_data  output  1  read requested while empty.

## Operation
- rx_serial passes through a 2-flop synchronizer (rx_s). Both flops reset to 1.
- Counters:
  - tick_cnt counts baud_ticks within a bit, width clog2(OVERSAMPLE).
  - bit_cnt counts data bits, width clog2(DATA_BITS).
  - shift_reg holds the data; bits arrive LSB first and are shifted in at the MSB.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - tick_cnt=0.
  - rx_s==0 -> START.
- START:
  - Each baud_tick increments tick_cnt.
  - At the baud_tick where tick_cnt==OVERSAMPLE/2-1 (mid start bit):
    - rx_s==0 -> DATA, tick_cnt=0, bit_cnt=0.
    - rx_s==1 -> IDLE (glitch rejected, nothing reported).
- DATA:
  - At the baud_tick where tick_cnt==OVERSAMPLE-1: shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]}, tick_cnt=0, bit_cnt++.
  - If bit_cnt==DATA_BITS-1 at that tick -> STOP.
- STOP: at the baud_tick where tick_cnt==OVERSAMPLE-1, the stop bit is sampled:
  - rx_s==1 and full==0: write=1 and rx_data=shift_reg for the next cycle -> IDLE.
  - rx_s==1 and full==1: error_overrun=1, write stays 0, byte discarded -> IDLE.
  - rx_s==0: error_framing=1, write stays 0 (regardless of full) -> WAIT_HIGH.
- WAIT_HIGH: stays until rx_s==1, then -> IDLE. A held-low line or break must not retrigger START.
- busy = (state != IDLE).
- Host side, combinational:
  - read = read_data & ~empty.
  - error_read_data = read_data & empty.
- baud_tick is ignored in IDLE and WAIT_HIGH. Between ticks, counters and state hold.

## Timing
- Reset values (sync, reset_n==0 at posedge):
  - state=IDLE, tick_cnt=0, bit_cnt=0, shift_reg=0.
  - rx_data=0, write=0, error_framing=0, error_overrun=0, busy=0.
  - Synchronizer flops=1.
  - read and error_read_data follow their combinational equations; both are 0 when read_data=0.
- Reset mid-frame aborts the frame. No write or error pulse is produced for it.
- Detection latency: a falling edge on rx_serial reaches rx_s 2 clks later. START is entered on the following edge.
- Sampling: data bit n is sampled (OVERSAMPLE/2 + (n+1)*OVERSAMPLE) ticks after START entry, which is mid-bit.
- write, rx_data, error_framing and error_overrun are registered.
  - They assert in the clk after the stop-sampling edge, for exactly 1 clk.
  - rx_data holds its value until the next write.
- Back-to-back frames are accepted: a start bit immediately following a valid stop bit is detected from IDLE with no dead time beyond synchronizer latency.
- Simultaneous read_data and write are independent: the FIFO handles the concurrent push and pop.
- A full that deasserts in the same cycle as the stop sample counts as not full only if it is already 0 at that edge.

## Test plan
- Default params, baud_tick every 4 clk, frame 0xA5 (LSB first, stop=1), full=0 -> exactly one write pulse with rx_data=0xA5; no error pulses; busy falls with write.
- rx_serial low for 3 baud_ticks, then high -> returns to IDLE after the mid-start check; write=0, no errors; next valid frame 0x3C is received correctly.
- Frame 0x3C with stop bit=0, line held low 40 ticks -> one error_framing pulse, write=0, busy=1 through WAIT_HIGH; busy=0 once the line goes high.
- full=1 during frame 0x5A -> one error_overrun pulse, write=0; with full=0, next frame 0x81 -> write with rx_data=0x81.
- read_data=1 with empty=1 -> read=0, error_read_data=1. read_data=1 with empty=0 -> read=1, error_read_data=0.
- reset_n=0 for 1 clk during DATA bit 4 of frame 0xFF -> all outputs 0, no write; a following frame 0x12 is received as 0x12.

Source files
------------

// File: rtl/uart_control_receiver.sv
// uart_control_receiver: 8N1 UART receive controller that pushes good bytes into the RX FIFO and gates host pops
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   baud_tick             one-clk pulse at OVERSAMPLE x baud rate
//   rx_serial             asynchronous serial line, idle high
//   full, empty           RX FIFO status
//   read_data             host pop request
//   rx_data, write        received byte and one-clk FIFO push strobe
//   read                  FIFO pop strobe (read_data gated by empty)
//   busy                  frame reception in progress
//   error_framing         one-clk pulse, stop bit sampled low
//   error_overrun         one-clk pulse, good byte dropped on a full FIFO
//   error_read_data       pop requested while the FIFO is empty
module uart_control_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 baud_tick,
  input  logic                 rx_serial,
  input  logic                 full,
  input  logic                 empty,
  input  logic                 read_data,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 write,
  output logic                 read,
  output logic                 busy,
  output logic                 error_framing,
  output logic                 error_overrun,
  output logic                 error_read_data
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t                 state_q;
  logic [1:0]             sync_q;
  logic [TW-1:0]          tick_q;
  logic [TW-1:0]          tick_d;
  logic [BW-1:0]          bit_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   shift_d;
  logic [DATA_BITS-1:0]   rx_data_q;
  logic                   write_q;
  logic                   err_f_q;
  logic                   err_o_q;
  logic                   rx_s;
  assign rx_s    = sync_q[1];
  // tick counter wraps explicitly so non-power-of-two oversampling works
  assign tick_d  = (tick_q == LAST) ? '0 : tick_q + TW'(1);
  assign shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sync_q    <= 2'b11;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      write_q   <= 1'b0;
      err_f_q   <= 1'b0;
      err_o_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_serial};
      write_q <= 1'b0;
      err_f_q <= 1'b0;
      err_o_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tick_q <= '0;
          if (!rx_s) state_q <= START;
        end
        START: if (baud_tick) begin
          if (tick_q == MID) begin
            // a line back high at mid start bit is a glitch, dropped silently
            tick_q  <= '0;
            bit_q   <= '0;
            state_q <= rx_s ? IDLE : DATA;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        DATA: if (baud_tick) begin
          tick_q <= tick_d;
          if (tick_q == LAST) begin
            shift_q <= shift_d;
            bit_q   <= bit_q + BW'(1);
            if (bit_q == LAST_BIT) state_q <= STOP;
          end
        end
        STOP: if (baud_tick) begin
          tick_q <= tick_d;
          if (tick_q == LAST) begin
            if (!rx_s) begin
              err_f_q <= 1'b1;
              state_q <= WAIT_HIGH;
            end else if (full) begin
              err_o_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              write_q   <= 1'b1;
              rx_data_q <= shift_q;
              state_q   <= IDLE;
            end
          end
        end
        // a held-low line or break must not be mistaken for a new start bit
        WAIT_HIGH: if (rx_s) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign rx_data         = rx_data_q;
  assign write           = write_q;
  assign error_framing   = err_f_q;
  assign error_overrun   = err_o_q;
  assign busy            = state_q != IDLE;
  assign read            = read_data & ~empty;
  assign error_read_data = read_data & empty;
endmodule

// File: tb/tb_uart_control_receiver.sv
// tb_uart_control_receiver: scoreboard bench driving random 8N1 frames against a frame-level outcome model
module tb_uart_control_receiver;
  localparam int BITCLK = 64;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rx_serial = 1'b1;
  logic       full = 1'b0;
  logic       empty = 1'b1;
  logic       read_data = 1'b0;
  logic [7:0] rx_data;
  logic       write;
  logic       read;
  logic       busy;
  logic       error_framing;
  logic       error_overrun;
  logic       error_read_data;
  int         errors = 0;
  int         checks = 0;
  int         tdiv = 0;
  int         exp_kind[$];
  logic [7:0] exp_data[$];
  logic [7:0] last_wr = 8'h00;
  uart_control_receiver dut (
    .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .rx_serial(rx_serial),
    .full(full), .empty(empty), .read_data(read_data), .rx_data(rx_data),
    .write(write), .read(read), .busy(busy), .error_framing(error_framing),
    .error_overrun(error_overrun), .error_read_data(error_read_data)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(negedge clk);
    baud_tick = (tdiv == 3);
    tdiv = (tdiv + 1) % 4;
  end
  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  // kind 0 = byte written, 1 = framing error, 2 = overrun
  initial begin
    int k;
    logic [7:0] d;
    forever begin
      @(negedge clk);
      if (write || error_framing || error_overrun) begin
        k = write ? 0 : error_framing ? 1 : 2;
        chk("single_pulse", int'(write) + int'(error_framing) + int'(error_overrun), 1);
        if (exp_kind.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got kind %0d expected none at %0t", k, $time);
        end else begin
          chk("event_kind", k, exp_kind.pop_front());
          d = exp_data.pop_front();
          if (k == 0) chk("rx_data", rx_data, d);
          chk("busy_at_event", busy, k == 1 ? 1 : 0);
        end
      end
    end
  end
  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(logic [7:0] d, bit stop, bit fl, int rst_at);
    full = fl;
    if (rst_at < 0) begin
      exp_kind.push_back(!stop ? 1 : fl ? 2 : 0);
      exp_data.push_back(d);
      if (stop && !fl) last_wr = d;
    end
    for (int c = 0; c < 10 * BITCLK; c++) begin
      @(negedge clk);
      reset_n = (c != rst_at);
      if (rst_at >= 0 && c == rst_at + 1) begin
        chk("rst_write", write, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_err_f", error_framing, 0);
        chk("rst_err_o", error_overrun, 0);
        last_wr = 8'h00;
      end
      rx_serial = c < BITCLK ? 1'b0 : c < 9 * BITCLK ? d[c / BITCLK - 1] : stop;
    end
    if (!stop) begin
      idle(160);
      chk("busy_wait_high", busy, 1);
      rx_serial = 1'b1;
      idle(8);
      chk("busy_after_high", busy, 0);
    end
  endtask
  task automatic glitch();
    @(negedge clk);
    rx_serial = 1'b0;
    idle(12);
    rx_serial = 1'b1;
    idle(64);
    chk("glitch_busy", busy, 0);
  endtask
  task automatic host_checks(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      read_data = 1'($urandom_range(0, 1));
      empty = 1'($urandom_range(0, 1));
      #1;
      chk("read", read, int'(read_data & ~empty));
      chk("error_read_data", error_read_data, int'(read_data & empty));
    end
    @(negedge clk);
    read_data = 1'b0;
  endtask
  initial begin
    int r;
    idle(4);
    chk("reset_write", write, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_err_f", error_framing, 0);
    chk("reset_err_o", error_overrun, 0);
    chk("reset_read", read, 0);
    chk("reset_err_rd", error_read_data, 0);
    reset_n = 1'b1;
    idle(20);
    send(8'hA5, 1'b1, 1'b0, -1);
    idle(10);
    glitch();
    send(8'h3C, 1'b1, 1'b0, -1);
    idle(10);
    send(8'h3C, 1'b0, 1'b0, -1);
    idle(10);
    send(8'h5A, 1'b1, 1'b1, -1);
    send(8'h81, 1'b1, 1'b0, -1);
    idle(10);
    send(8'hFF, 1'b1, 1'b0, 5 * BITCLK + BITCLK / 2);
    idle(20);
    send(8'h12, 1'b1, 1'b0, -1);
    read_data = 1'b1;
    empty = 1'b1;
    #1;
    chk("rd_empty_read", read, 0);
    chk("rd_empty_err", error_read_data, 1);
    empty = 1'b0;
    #1;
    chk("rd_ok_read", read, 1);
    chk("rd_ok_err", error_read_data, 0);
    host_checks(16);
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) glitch();
      else send(8'($urandom), r != 1, r == 2, -1);
      idle($urandom_range(0, 40));
    end
    full = 1'b0;
    for (int i = 0; i < 2000 && exp_kind.size() > 0; i++) @(negedge clk);
    while (exp_kind.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: missing event kind %0d data %0h", exp_kind.pop_front(), exp_data.pop_front());
    end
    idle(10);
    chk("rx_data_hold", rx_data, last_wr);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
